// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, 2-entry output FIFO, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise sticky misalign_o and block fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [31:0] instr_pc_plus4_o,
    output logic        misalign_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] opc_q, opc_d;
    logic [63:0] fifo_q [2];
    logic [63:0] fifo_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] redir_pc;
    logic        outstanding;
    logic        push;
    logic        pop;
    logic [63:0] head;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign redir_pc   = redirect_pc_i;
    assign misalign_o = misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect_i) begin
            misalign_d = |redirect_pc_i[1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    logic unused_redir_bits;

    assign unused_redir_bits = ^redirect_pc_i[1:0];
    assign redir_pc          = {redirect_pc_i[31:2], 2'b00};
    assign misalign_o        = 1'b0;
`endif

    assign outstanding = (state_q == S_WAIT);
    // The FIFO slot for the in-flight word is reserved at request time, so a push never overflows.
    assign imem_req_o  = !rst_i && (state_q == S_REQ)
                         && (({1'b0, count_q} + {2'b00, outstanding}) < 3'd2)
                         && !redirect_i && !misalign_o;
    assign imem_addr_o = pc_q;

    assign head             = fifo_q[rd_ptr_q];
    assign instr_valid_o    = !rst_i && (count_q != 2'd0);
    assign instr_o          = head[63:32];
    assign instr_pc_o       = head[31:0];
    assign instr_pc_plus4_o = head[31:0] + 32'd4;
    assign pop              = instr_valid_o && !stall_i;
    assign dbg_state_o      = state_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opc_d    = opc_q;
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push     = 1'b0;

        if (redirect_i) begin
            pc_d     = redir_pc;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            case (state_q)
                S_WAIT:  state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_o && imem_gnt_i) begin
                        opc_d   = pc_q;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        push    = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid_i) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase

            if (push) begin
                fifo_d[wr_ptr_q] = {imem_rdata_i, opc_q};
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            opc_q    <= 32'h0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opc_q    <= opc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk_i) begin
        fifo_q[0] <= fifo_d[0];
        fifo_q[1] <= fifo_d[1];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder with grant budget and latency,
// expected-instruction scoreboard checked by an independent monitor.
module tb_fetch_unit;
  localparam int W = 96;

  logic        clk;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] instr_pc_plus4_o;
  logic        misalign_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int grants_left = 0;
  int lat = 1;
  int pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i),
    .instr_valid_o(instr_valid_o),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o),
    .instr_pc_plus4_o(instr_pc_plus4_o),
    .misalign_o(misalign_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // memory responder: instruction word is ~address, rvalid lat cycles after the grant
  always @(posedge clk) begin
    logic fire;
    logic [31:0] addr;
    fire = imem_req_o && imem_gnt_i;
    addr = imem_addr_o;
    #1;
    imem_rvalid_i = 1'b0;
    if (fire) begin
      grants_left--;
      pend_addr = addr;
      pend_cnt  = lat;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = ~pend_addr;
      end
    end
    imem_gnt_i = (grants_left > 0);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_i && instr_valid_o && !stall_i && !redirect_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr actual pc=%h instr=%h required=no_output", instr_pc_o, instr_o);
      end else begin
        e = exp_q.pop_front();
        if ({instr_o, instr_pc_o, instr_pc_plus4_o} !== e) begin
          errors++;
          $display("FAIL instr_out actual=%h/%h/%h required=%h/%h/%h",
                   instr_o, instr_pc_o, instr_pc_plus4_o, e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    exp_q.push_back({instr, pc, pc4});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      next_cycle();
      sample();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d_left required=0", name, exp_q.size());
    end
    repeat (3) begin
      next_cycle();
      sample();
    end
  endtask

  task automatic wait_fire(input string name);
    int n;
    n = 0;
    next_cycle();
    sample();
    while (!(imem_req_o && imem_gnt_i) && n < 10) begin
      next_cycle();
      sample();
      n++;
    end
    check({name, "_grant"}, {31'h0, imem_req_o && imem_gnt_i}, 32'h1);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    next_cycle();
    redirect_i    = 1'b0;
    sample();
  endtask

  initial begin
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    stall_i       = 1'b0;

    // reset state
    repeat (3) next_cycle();
    sample();
    check("rst_req", {31'h0, imem_req_o}, 32'h0);
    check("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    check("rst_misalign", {31'h0, misalign_o}, 32'h0);

    // zero-wait fetch after reset release
    grants_left = 3;
    exp_push(32'hFFFF_FEFF, 32'h0000_0100, 32'h0000_0104);
    exp_push(32'hFFFF_FEFB, 32'h0000_0104, 32'h0000_0108);
    exp_push(32'hFFFF_FEF7, 32'h0000_0108, 32'h0000_010C);
    next_cycle();
    rst_i = 1'b0;
    sample();
    check("first_req", {31'h0, imem_req_o}, 32'h1);
    check("first_addr", imem_addr_o, 32'h0000_0100);
    next_cycle();
    sample();
    check("wait_no_req", {31'h0, imem_req_o}, 32'h0);
    check("wait_no_valid", {31'h0, instr_valid_o}, 32'h0);
    next_cycle();
    sample();
    check("lat2_valid", {31'h0, instr_valid_o}, 32'h1);
    check("second_addr", imem_addr_o, 32'h0000_0104);
    drain("basic");
    check("idle_addr", imem_addr_o, 32'h0000_010C);

    // stall: two entries buffered, no request while full
    grants_left = 3;
    exp_push(32'hFFFF_FEF3, 32'h0000_010C, 32'h0000_0110);
    exp_push(32'hFFFF_FEEF, 32'h0000_0110, 32'h0000_0114);
    exp_push(32'hFFFF_FEEB, 32'h0000_0114, 32'h0000_0118);
    next_cycle();
    stall_i = 1'b1;
    repeat (10) begin
      next_cycle();
      sample();
    end
    check("stall_valid", {31'h0, instr_valid_o}, 32'h1);
    check("stall_full_no_req", {31'h0, imem_req_o}, 32'h0);
    check("stall_head_pc", instr_pc_o, 32'h0000_010C);
    check("stall_queue", exp_q.size(), 32'd3);
    next_cycle();
    stall_i = 1'b0;
    drain("stall");

    // redirect while WAIT, stale word arrives 3 cycles after grant
    grants_left = 2;
    lat = 3;
    wait_fire("redir");
    check("redir_grant_addr", imem_addr_o, 32'h0000_0118);
    next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    sample();
    check("redir_state_wait", {30'h0, dbg_state_o}, 32'h1);
    lat = 1;
    exp_push(32'hFFFF_FDFF, 32'h0000_0200, 32'h0000_0204);
    next_cycle();
    redirect_i = 1'b0;
    sample();
    check("drain_no_req", {31'h0, imem_req_o}, 32'h0);
    check("drain_no_valid", {31'h0, instr_valid_o}, 32'h0);
    next_cycle();
    sample();
    check("drain_discard_valid", {31'h0, instr_valid_o}, 32'h0);
    check("drain_discard_req", {31'h0, imem_req_o}, 32'h0);
    next_cycle();
    sample();
    check("redir_req", {31'h0, imem_req_o}, 32'h1);
    check("redir_addr", imem_addr_o, 32'h0000_0200);
    check("redir_no_stale", {31'h0, instr_valid_o}, 32'h0);
    drain("redir");

    // pc wrap at top of address space
    grants_left = 1;
    exp_push(32'h0000_0003, 32'hFFFF_FFFC, 32'h0000_0000);
    pulse_redirect(32'hFFFF_FFFC);
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    drain("wrap");
    check("wrap_next_addr", imem_addr_o, 32'h0000_0000);
    check("wrap_next_req", {31'h0, imem_req_o}, 32'h1);

`ifdef FETCH_MISALIGN_TRAP_EN
    // misaligned redirect traps until an aligned redirect
    pulse_redirect(32'h0000_0202);
    check("mis_set", {31'h0, misalign_o}, 32'h1);
    check("mis_no_req", {31'h0, imem_req_o}, 32'h0);
    grants_left = 1;
    repeat (3) begin
      next_cycle();
      sample();
    end
    check("mis_still_blocked", {31'h0, imem_req_o}, 32'h0);
    exp_push(32'hFFFF_FCFF, 32'h0000_0300, 32'h0000_0304);
    pulse_redirect(32'h0000_0300);
    check("mis_clear", {31'h0, misalign_o}, 32'h0);
    check("mis_clear_addr", imem_addr_o, 32'h0000_0300);
    drain("mis");
`else
    // low bits of a misaligned redirect are dropped
    grants_left = 1;
    exp_push(32'hFFFF_FDFF, 32'h0000_0200, 32'h0000_0204);
    pulse_redirect(32'h0000_0202);
    check("align_addr", imem_addr_o, 32'h0000_0200);
    check("align_misalign", {31'h0, misalign_o}, 32'h0);
    drain("align");
`endif

    // reset mid-transaction, stale rvalid later ignored
    grants_left = 1;
    lat = 3;
    wait_fire("rst_mid");
    next_cycle();
    rst_i = 1'b1;
    sample();
    check("rst_mid_req", {31'h0, imem_req_o}, 32'h0);
    next_cycle();
    rst_i = 1'b0;
    sample();
    check("rst_mid_addr", imem_addr_o, 32'h0000_0100);
    check("rst_mid_state", {30'h0, dbg_state_o}, 32'h0);
    repeat (5) begin
      next_cycle();
      sample();
      check("rst_mid_no_valid", {31'h0, instr_valid_o}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
